fetch_ctrl_unit: RTL and testbench

- Fetch/control subassembly of the 9-bit-instruction processor.
- Holds the program counter and decodes the 3-bit opcode into datapath control strobes.
- Resolves relative jumps through an internal 8-entry offset lookup table and absolute jumps from a register value.
- Sits between instruction ROM (consumes prog_ctr, returns instr) and the register file/ALU/data memory (consumes control strobes, supplies inB and absjump_en).

---
 rtl/fetch_ctrl_unit_if.sv | 31 +++
 rtl/fetch_ctrl_unit.sv | 95 +++++++++
 tb/tb_fetch_ctrl_unit.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_unit_if.sv
// rtl/fetch_ctrl_unit_if.sv - instruction/operand inputs and PC/control-strobe outputs of the fetch unit
interface fetch_ctrl_unit_if #(
    parameter int D = 12,
    parameter int A = 3
);
    logic [8:0]   instr;
    logic [7:0]   inB;
    logic         absjump_en;
    logic [D-1:0] prog_ctr;
    logic [D-1:0] target;
    logic         done;
    logic         reg_dst;
    logic         branch;
    logic         mem_write;
    logic         alu_src;
    logic         reg_write;
    logic         mem_to_reg;
    logic [A-1:0] alu_op;

    modport master (
        output instr, inB, absjump_en,
        input  prog_ctr, target, done, reg_dst, branch, mem_write,
        input  alu_src, reg_write, mem_to_reg, alu_op
    );

    modport slave (
        input  instr, inB, absjump_en,
        output prog_ctr, target, done, reg_dst, branch, mem_write,
        output alu_src, reg_write, mem_to_reg, alu_op
    );
endinterface

// File: rtl/fetch_ctrl_unit.sv
// rtl/fetch_ctrl_unit.sv - program counter, jump-offset LUT and opcode decode of the 9-bit-instruction processor
// Optional macro FETCH_COND_BRANCH_EN gates relative branches with the registered zero flag.
module fetch_ctrl_unit #(
    parameter int D       = 12,
    parameter int A       = 3,
    parameter int DONE_PC = 296
) (
    input  logic              clk,
    input  logic              reset,
`ifdef FETCH_COND_BRANCH_EN
    input  logic              zero_q,
`endif
    fetch_ctrl_unit_if.slave  bus
);

    logic [2:0]   opcode;
    logic [2:0]   lut_idx;
    logic [D-1:0] target_lut;
    logic [D-1:0] prog_ctr_d;
    logic [D-1:0] prog_ctr_q;
    logic         branch_taken;
    logic         unused_rega;

    assign opcode      = bus.instr[8:6];
    assign lut_idx     = bus.instr[2:0];
    assign unused_rega = ^bus.instr[5:3];

    // Offsets are D-bit two's complement so adding them to the PC wraps naturally.
    always_comb begin
        target_lut = '0;
        case (lut_idx)
            3'd0:    target_lut = '0;
            3'd1:    target_lut = D'(2);
            3'd2:    target_lut = D'(4);
            3'd3:    target_lut = -(D'(4));
            3'd4:    target_lut = -(D'(8));
            3'd5:    target_lut = -(D'(16));
            3'd6:    target_lut = D'(16);
            3'd7:    target_lut = -(D'(32));
            default: target_lut = '0;
        endcase
    end

`ifdef FETCH_COND_BRANCH_EN
    assign branch_taken = (opcode == 3'b110) && zero_q;
`else
    assign branch_taken = (opcode == 3'b110);
`endif

    always_comb begin
        bus.reg_write  = 1'b0;
        bus.alu_src    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.mem_write  = 1'b0;
        case (opcode)
            3'b000, 3'b100, 3'b101: bus.reg_write = 1'b1;
            3'b001: begin
                bus.reg_write = 1'b1;
                bus.alu_src   = 1'b1;
            end
            3'b010: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            3'b011:  bus.mem_write = 1'b1;
            default: bus.reg_write = 1'b0;
        endcase
    end

    // Absolute jump outranks a simultaneous relative branch.
    always_comb begin
        prog_ctr_d = prog_ctr_q + D'(1);
        if (bus.absjump_en) begin
            prog_ctr_d = {{(D-8){1'b0}}, bus.inB};
        end else if (branch_taken) begin
            prog_ctr_d = prog_ctr_q + target_lut;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prog_ctr_q <= '0;
        end else begin
            prog_ctr_q <= prog_ctr_d;
        end
    end

    assign bus.prog_ctr = prog_ctr_q;
    assign bus.target   = target_lut;
    assign bus.done     = (prog_ctr_q == D'(DONE_PC));
    assign bus.reg_dst  = 1'b0;
    assign bus.branch   = branch_taken;
    assign bus.alu_op   = bus.instr[8 -: A];

endmodule

// File: tb/tb_fetch_ctrl_unit.sv
// tb/tb_fetch_ctrl_unit.sv - scoreboard bench for fetch_ctrl_unit with a behavioural PC/decode model
module tb_fetch_ctrl_unit;

    localparam int D = 12;
    localparam int A = 3;
    localparam int MODULUS = 4096;

    typedef struct {
        int         pc;
        int         tgt;
        bit         dn;
        logic [8:0] ctrl;
    } exp_t;

    logic clk;
    logic reset;
    logic zero_q_tb;

    fetch_ctrl_unit_if #(.D(D), .A(A)) bus ();

    fetch_ctrl_unit #(.D(D), .A(A), .DONE_PC(296)) dut (
        .clk    (clk),
        .reset  (reset),
`ifdef FETCH_COND_BRANCH_EN
        .zero_q (zero_q_tb),
`endif
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   model_pc = 0;

    int offs[8] = '{0, 2, 4, -4, -8, -16, 16, -32};
    // reg_write, alu_src, mem_to_reg, mem_write, branch
    bit [4:0] dec[8] = '{5'b10000, 5'b11000, 5'b10100, 5'b00010,
                         5'b10000, 5'b10000, 5'b00001, 5'b00000};

    function automatic int wrap(input int x);
        return ((x % MODULUS) + MODULUS) % MODULUS;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic [8:0] ins, input logic [7:0] b, input bit ab,
                        input bit rst_v, input bit zq);
        exp_t     e;
        int       op;
        int       idx;
        bit [4:0] d;
        bit       br;
        @(negedge clk);
        reset          = rst_v;
        bus.instr      = ins;
        bus.inB        = b;
        bus.absjump_en = ab;
        zero_q_tb      = zq;
        op  = int'(ins[8:6]);
        idx = int'(ins[2:0]);
        d   = dec[op];
`ifdef FETCH_COND_BRANCH_EN
        br  = d[0] & zq;
`else
        br  = d[0];
`endif
        if (!rst_v) model_pc = 0;
        e.pc   = model_pc;
        e.tgt  = wrap(offs[idx]);
        e.dn   = (model_pc == 296);
        e.ctrl = {1'b0, br, d[1], d[3], d[4], d[2], ins[8:6]};
        exp_q.push_back(e);
        if (!rst_v)      model_pc = 0;
        else if (ab)     model_pc = int'(b);
        else if (br)     model_pc = wrap(model_pc + offs[idx]);
        else             model_pc = wrap(model_pc + 1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("prog_ctr", int'(bus.prog_ctr), e.pc);
                check("target", int'(bus.target), e.tgt);
                check("done", int'(bus.done), int'(e.dn));
                check("ctrl", int'({bus.reg_dst, bus.branch, bus.mem_write, bus.alu_src,
                                    bus.reg_write, bus.mem_to_reg, bus.alu_op}), int'(e.ctrl));
            end
        end
    end

    initial begin : stim
        reset          = 1'b0;
        bus.instr      = '0;
        bus.inB        = '0;
        bus.absjump_en = 1'b0;
        zero_q_tb      = 1'b1;
        #1;
        n_tests++;
        if (bus.prog_ctr !== '0) begin
            n_fail++;
            $display("FAIL reset_pc: got %0d expected 0", bus.prog_ctr);
        end
        repeat (3) @(posedge clk);

        // release reset then count 0..5
        for (int i = 0; i < 6; i++) step(9'b000_000_000, 8'h00, 1'b0, 1'b1, 1'b1);

        // relative branches from PC 10
        step(9'b000_000_000, 8'd10, 1'b1, 1'b1, 1'b1);
        step(9'b110_000_011, 8'h00, 1'b0, 1'b1, 1'b1);
        step(9'b000_000_000, 8'd10, 1'b1, 1'b1, 1'b1);
        step(9'b110_000_110, 8'h00, 1'b0, 1'b1, 1'b1);
        step(9'b110_000_000, 8'h00, 1'b0, 1'b1, 1'b1);

        // absolute beats branch
        step(9'b110_000_110, 8'hC8, 1'b1, 1'b1, 1'b1);
        step(9'b000_000_000, 8'h00, 1'b0, 1'b1, 1'b1);

        // done boundary around 296
        step(9'b000_000_000, 8'd250, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 49; i++) step(9'b000_000_000, 8'h00, 1'b0, 1'b1, 1'b1);

        // opcode sweep
        for (int op = 0; op < 8; op++)
            step({op[2:0], 3'b101, 3'b010}, 8'h00, 1'b0, 1'b1, 1'b1);

        // async reset mid-count at 37
        step(9'b000_000_000, 8'd37, 1'b1, 1'b1, 1'b1);
        step(9'b000_000_000, 8'h00, 1'b0, 1'b1, 1'b1);
        step(9'b001_000_111, 8'h00, 1'b0, 1'b0, 1'b1);
        step(9'b000_000_000, 8'h00, 1'b0, 1'b1, 1'b1);
        step(9'b000_000_000, 8'h00, 1'b0, 1'b1, 1'b1);

        // wrap: 0 - 4 -> 4092, then increments through 4095 -> 0
        step(9'b000_000_000, 8'd0, 1'b1, 1'b1, 1'b1);
        step(9'b110_000_011, 8'h00, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(9'b000_000_000, 8'h00, 1'b0, 1'b1, 1'b1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(9'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 63) != 0), 1'($urandom));
        end
        step(9'b000_000_000, 8'h00, 1'b0, 1'b1, 1'b1);

        repeat (2) @(negedge clk);
        #5;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
